// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory read-modify-write sequencer:
// store/load op codes, sequencer states and big-endian byte-lane helpers.
package dmem_pkg;

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_B  = 3'd2;
    localparam logic [2:0] OP_WL = 3'd3;
    localparam logic [2:0] OP_WR = 3'd4;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Byte lane idx of a word, lane 0 being the most significant byte.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input int idx);
        return w[(LANES * BYTE_W - 1) - BYTE_W * idx -: 8];
    endfunction

endpackage

// File: rtl/dmem_merge.sv
// Combinational byte-lane merge for partial stores, plus the per-op flags
// telling the sequencer whether the old word must be read and whether the op is illegal.
module dmem_merge
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  op,
    input  logic [1:0]  k,
    input  logic        write,
    output logic [31:0] new_word,
    output logic        needs_read,
    output logic        misaligned
);

    // Lane-by-lane select between the old word and the shifted store data.
    always_comb begin
        new_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            case (op)
                OP_W: new_word[31 - BYTE_W * i -: 8] = get_byte(wdata, i);
                OP_H: begin
                    if ((i / 2) == (int'(k) / 2)) begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(wdata, 2 + (i % 2));
                    end else begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(old_word, i);
                    end
                end
                OP_B: begin
                    if (i == int'(k)) begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(wdata, 3);
                    end else begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(old_word, i);
                    end
                end
                OP_WL: begin
                    if (i >= int'(k)) begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(wdata, i - int'(k));
                    end else begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(old_word, i);
                    end
                end
                OP_WR: begin
                    if (i <= int'(k)) begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(wdata, 3 - int'(k) + i);
                    end else begin
                        new_word[31 - BYTE_W * i -: 8] = get_byte(old_word, i);
                    end
                end
                default: new_word[31 - BYTE_W * i -: 8] = get_byte(old_word, i);
            endcase
        end
    end

    // Stores that overwrite every lane skip the read; undefined store codes are rejected.
    always_comb begin
        needs_read = 1'b1;
        misaligned = 1'b0;
        if (write) begin
            case (op)
                OP_W: begin
                    needs_read = 1'b0;
                    misaligned = (k != 2'd0);
                end
                OP_H: begin
                    needs_read = 1'b1;
                    misaligned = k[0];
                end
                OP_B: begin
                    needs_read = 1'b1;
                    misaligned = 1'b0;
                end
                OP_WL: begin
                    needs_read = (k != 2'd0);
                    misaligned = 1'b0;
                end
                OP_WR: begin
                    needs_read = (k != 2'd3);
                    misaligned = 1'b0;
                end
                default: begin
                    needs_read = 1'b0;
                    misaligned = 1'b1;
                end
            endcase
        end else begin
            needs_read = 1'b1;
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_rmw_sequencer.sv
// Owns the word-only data memory port: single accesses for loads and full-word
// stores, read-merge-write for partial stores, with per-transaction ack timeout.
module dmem_rmw_sequencer
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err_OUT,
    output logic        stall_OUT,
    output logic [31:0] dm_addr,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       dm_addr_q, dm_addr_d;
    logic              dm_read_q, dm_read_d;
    logic              dm_write_q, dm_write_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              err_q, err_d;

    logic [31:0]       m_old_s, m_wdata_s, m_new_s;
    logic [2:0]        m_op_s;
    logic [1:0]        m_k_s;
    logic              m_write_s, m_needs_read_s, m_misaligned_s;

    // In IDLE the merge sees the live request; afterwards the latched one, with
    // the word arriving from memory while the read is being acknowledged.
    always_comb begin
        if (state_q == IDLE) begin
            m_write_s = req_write;
            m_op_s    = req_write ? req_op : OP_W;
            m_k_s     = req_addr[1:0];
            m_wdata_s = req_wdata;
        end else begin
            m_write_s = write_q;
            m_op_s    = op_q;
            m_k_s     = k_q;
            m_wdata_s = wdata_q;
        end
        if (state_q == RD) begin
            m_old_s = dm_rdata;
        end else begin
            m_old_s = rdata_q;
        end
    end

    dmem_merge u_merge (
        .old_word   (m_old_s),
        .wdata      (m_wdata_s),
        .op         (m_op_s),
        .k          (m_k_s),
        .write      (m_write_s),
        .new_word   (m_new_s),
        .needs_read (m_needs_read_s),
        .misaligned (m_misaligned_s)
    );

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        op_d        = op_q;
        k_d         = k_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        dm_addr_d   = dm_addr_q;
        dm_read_d   = dm_read_q;
        dm_write_d  = dm_write_q;
        dm_wdata_d  = dm_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d   = req_write;
                    op_d      = m_op_s;
                    k_d       = req_addr[1:0];
                    wdata_d   = req_wdata;
                    dm_addr_d = {req_addr[31:2], 2'b00};
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    if (m_misaligned_s) begin
                        state_d     = RESP;
                        err_d       = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0000_0000;
                    end else if (m_needs_read_s) begin
                        state_d   = RD;
                        dm_read_d = 1'b1;
                    end else begin
                        state_d    = WR;
                        dm_write_d = 1'b1;
                        dm_wdata_d = m_new_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (dm_ack) begin
                    rdata_d   = dm_rdata;
                    dm_read_d = 1'b0;
                    cnt_d     = '0;
                    if (write_q) begin
                        state_d    = WR;
                        dm_write_d = 1'b1;
                        dm_wdata_d = m_new_s;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = dm_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    dm_read_d   = 1'b0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                if (dm_ack) begin
                    state_d     = RESP;
                    dm_write_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    dm_write_d  = 1'b0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                dm_read_d  = 1'b0;
                dm_write_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset abandons any in-flight op.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            op_q        <= OP_W;
            k_q         <= 2'd0;
            wdata_q     <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            cnt_q       <= '0;
            dm_addr_q   <= 32'h0000_0000;
            dm_read_q   <= 1'b0;
            dm_write_q  <= 1'b0;
            dm_wdata_q  <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            op_q        <= op_d;
            k_q         <= k_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            dm_addr_q   <= dm_addr_d;
            dm_read_q   <= dm_read_d;
            dm_write_q  <= dm_write_d;
            dm_wdata_q  <= dm_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign stall_OUT = (state_q == RD) || (state_q == WR) || ((state_q == IDLE) && req_valid);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_OUT   = err_q;
    assign dm_addr   = dm_addr_q;
    assign dm_read   = dm_read_q;
    assign dm_write  = dm_write_q;
    assign dm_wdata  = dm_wdata_q;

endmodule

// File: tb/tb_dmem_rmw_sequencer.sv
// Scoreboard bench for dmem_rmw_sequencer: a responding word memory, expected
// memory transactions and responses queued at issue, checked by a negedge monitor.
module tb_dmem_rmw_sequencer;
    import dmem_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, err_OUT, stall_OUT;
    logic [31:0] rsp_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_read, dm_write, dm_ack;

    logic        ack_rd, ack_wr;
    logic        pl_en;
    logic [31:0] pl_addr, pl_data;
    logic [31:0] mem [0:255];

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } dm_exp_t;
    typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_exp_t;
    dm_exp_t  exp_dm[$];
    rsp_exp_t exp_rsp[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_seen = 0;
    int nexp = 0;
    int strobe_cnt = 0;

    dmem_rmw_sequencer #(.TIMEOUT(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .err_OUT   (err_OUT),
        .stall_OUT (stall_OUT),
        .dm_addr   (dm_addr),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign dm_ack   = (dm_read && ack_rd) || (dm_write && ack_wr);
    assign dm_rdata = mem[dm_addr[9:2]];

    // Memory model: acknowledged writes and bench preloads.
    always @(posedge CLK) begin
        if (pl_en) begin
            mem[pl_addr[9:2]] <= pl_data;
        end else if (dm_write && dm_ack) begin
            mem[dm_addr[9:2]] <= dm_wdata;
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    function automatic void exp_read(input logic [31:0] a);
        dm_exp_t e;
        e.wr = 1'b0; e.addr = a; e.data = 32'h0;
        exp_dm.push_back(e);
    endfunction

    function automatic void exp_write(input logic [31:0] a, input logic [31:0] d);
        dm_exp_t e;
        e.wr = 1'b1; e.addr = a; e.data = d;
        exp_dm.push_back(e);
    endfunction

    function automatic void exp_resp(input logic [31:0] r, input logic e, input int lat);
        rsp_exp_t x;
        x.rdata = r; x.err = e; x.lat = lat;
        exp_rsp.push_back(x);
        nexp++;
    endfunction

    task automatic monitor();
        dm_exp_t  d;
        rsp_exp_t r;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                if (dm_read && dm_write) begin
                    chk("strobe_excl", {dm_read, dm_write}, 2'b00);
                end
                if (dm_read || dm_write) strobe_cnt++;
                if (req_valid && req_ready) acc_cyc = cyc;
                if ((dm_read || dm_write) && dm_ack) begin
                    if (exp_dm.size() == 0) begin
                        chk("unexpected_dm", {dm_read, dm_write}, 2'b00);
                    end else begin
                        d = exp_dm.pop_front();
                        chk("dm_kind", {31'd0, dm_write}, {31'd0, d.wr});
                        chk("dm_addr", dm_addr, d.addr);
                        if (d.wr) chk("dm_wdata", dm_wdata, d.data);
                    end
                end
                if (rsp_valid) begin
                    rsp_seen++;
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_rdata", rsp_rdata, r.rdata);
                        chk("rsp_err", {31'd0, err_OUT}, {31'd0, r.err});
                        chk("rsp_latency", cyc - acc_cyc, r.lat);
                    end
                end
            end
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge CLK); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(posedge CLK); #1;
        while (!req_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_op = op; req_addr = a; req_wdata = d;
        #1;
        chk("stall_on_req", {31'd0, stall_OUT}, 32'd1);
        @(posedge CLK); #1;
        req_valid = 1'b0; req_write = ~w; req_op = OP_B; req_addr = 32'h0000_0003;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (rsp_seen < nexp && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        if (rsp_seen < nexp) chk("rsp_timeout", rsp_seen, nexp);
    endtask

    task automatic run_op(input logic w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        issue(w, op, a, d);
        wait_rsp();
    endtask

    initial begin
        int n;
        RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_op = OP_W;
        req_addr = 32'h0; req_wdata = 32'h0;
        ack_rd = 1'b1; ack_wr = 1'b1; pl_en = 1'b0; pl_addr = 32'h0; pl_data = 32'h0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_err", {31'd0, err_OUT}, 32'd0);
        chk("rst_strobes", {30'd0, dm_read, dm_write}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_stall", {31'd0, stall_OUT}, 32'd0);
        RESET = 1'b1;

        // Load, single access.
        preload(32'h100, 32'hDEADBEEF);
        exp_read(32'h100); exp_resp(32'hDEADBEEF, 1'b0, 2);
        run_op(1'b0, OP_W, 32'h100, 32'h0);

        // Byte stores.
        preload(32'h100, 32'h11223344);
        exp_read(32'h100); exp_write(32'h100, 32'h11223355); exp_resp(32'h0, 1'b0, 3);
        run_op(1'b1, OP_B, 32'h103, 32'h0000_0055);
        preload(32'h100, 32'h11223344);
        exp_read(32'h100); exp_write(32'h100, 32'h11553344); exp_resp(32'h0, 1'b0, 3);
        run_op(1'b1, OP_B, 32'h101, 32'h0000_0055);

        // Unaligned-word stores.
        preload(32'h200, 32'h11223344);
        exp_read(32'h200); exp_write(32'h200, 32'h11AABBCC); exp_resp(32'h0, 1'b0, 3);
        run_op(1'b1, OP_WL, 32'h201, 32'hAABBCCDD);
        preload(32'h200, 32'h11223344);
        exp_read(32'h200); exp_write(32'h200, 32'hCCDD3344); exp_resp(32'h0, 1'b0, 3);
        run_op(1'b1, OP_WR, 32'h201, 32'hAABBCCDD);
        exp_write(32'h200, 32'hAABBCCDD); exp_resp(32'h0, 1'b0, 2);
        run_op(1'b1, OP_WR, 32'h203, 32'hAABBCCDD);

        // Halfwords, full word and a load carrying a non-word op.
        preload(32'h100, 32'h11223344);
        exp_read(32'h100); exp_write(32'h100, 32'h11221234); exp_resp(32'h0, 1'b0, 3);
        run_op(1'b1, OP_H, 32'h102, 32'h0000_1234);
        exp_read(32'h100); exp_write(32'h100, 32'h56781234); exp_resp(32'h0, 1'b0, 3);
        run_op(1'b1, OP_H, 32'h100, 32'hABCD_5678);
        exp_write(32'h300, 32'h01020304); exp_resp(32'h0, 1'b0, 2);
        run_op(1'b1, OP_W, 32'h300, 32'h01020304);
        exp_read(32'h100); exp_resp(32'h56781234, 1'b0, 2);
        run_op(1'b0, OP_B, 32'h103, 32'h0);

        // Misaligned stores: no strobes at all.
        strobe_cnt = 0;
        exp_resp(32'h0, 1'b1, 1);
        run_op(1'b1, OP_H, 32'h101, 32'h0000_1234);
        exp_resp(32'h0, 1'b1, 1);
        run_op(1'b1, OP_W, 32'h102, 32'h01020304);
        chk("misaligned_strobes", strobe_cnt, 32'd0);

        // Ack never comes: abort after TIMEOUT strobe cycles.
        ack_rd = 1'b0;
        strobe_cnt = 0;
        exp_resp(32'h0, 1'b1, 5);
        issue(1'b0, OP_W, 32'h100, 32'h0);
        @(posedge CLK); #1;
        chk("stall_in_rd", {31'd0, stall_OUT}, 32'd1);
        chk("read_held", {31'd0, dm_read}, 32'd1);
        wait_rsp();
        chk("timeout_strobes", strobe_cnt, 32'd4);
        chk("timeout_read_drop", {31'd0, dm_read}, 32'd0);
        ack_rd = 1'b1;
        exp_read(32'h200); exp_resp(32'hAABBCCDD, 1'b0, 2);
        run_op(1'b0, OP_W, 32'h200, 32'h0);

        // Reset while the write of an RMW is pending.
        ack_wr = 1'b0;
        preload(32'h100, 32'h11223344);
        exp_read(32'h100);
        issue(1'b1, OP_B, 32'h100, 32'h0000_0077);
        n = 0;
        while (!dm_write && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("rmw_write_phase", {31'd0, dm_write}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("reset_write_drop", {31'd0, dm_write}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
        ack_wr = 1'b1;
        preload(32'h100, 32'h11223344);
        exp_read(32'h100); exp_write(32'h100, 32'h77223344); exp_resp(32'h0, 1'b0, 3);
        run_op(1'b1, OP_B, 32'h100, 32'h0000_0077);

        repeat (3) @(posedge CLK);
        #1;
        chk("dm_queue_empty", exp_dm.size(), 32'd0);
        chk("rsp_queue_empty", exp_rsp.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
